// File: rtl/tlb_pkg.sv
// Shared types for the CP0 TLB op controller: entry layout, op codes and EntryLo fields.
package tlb_pkg;

    typedef enum logic [1:0] {
        TLBOP_P  = 2'b00,
        TLBOP_R  = 2'b01,
        TLBOP_WI = 2'b10,
        TLBOP_WR = 2'b11
    } tlb_op_e;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    localparam int unsigned ENTRY_W    = $bits(tlb_entry_t);
    localparam int unsigned LO_PFN_MSB = 25;
    localparam int unsigned LO_PFN_LSB = 6;
    localparam int unsigned LO_C_MSB   = 5;
    localparam int unsigned LO_C_LSB   = 3;
    localparam int unsigned LO_D       = 2;
    localparam int unsigned LO_V       = 1;
    localparam int unsigned LO_G       = 0;

    // Rebuild a CP0 EntryLo word from one half of a TLB entry.
    function automatic logic [31:0] make_entrylo(input logic [19:0] pfn, input logic [2:0] c,
                                                 input logic d, input logic v, input logic g);
        return {6'b0, pfn, c, d, v, g};
    endfunction

endpackage

// File: rtl/tlb_random.sv
// CP0 Random register: counts down each cycle, wrapping from Wired back to the top entry.
module tlb_random
    import tlb_pkg::*;
#(
    parameter  int unsigned TLBNUM = 16,
    localparam int unsigned IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] wired_i,
    input  logic          wired_we_i,
    output logic [IW-1:0] random_o
);

    localparam logic [IW-1:0] RAND_TOP = IW'(TLBNUM - 1);

    logic [IW-1:0] random_q;
    logic [IW-1:0] random_d;

    // A Wired write or reaching Wired (or anything below it) restarts at the top.
    always_comb begin
        random_d = random_q - IW'(1);
        if (wired_we_i || (random_q <= wired_i)) begin
            random_d = RAND_TOP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            random_q <= RAND_TOP;
        end else begin
            random_q <= random_d;
        end
    end

    assign random_o = random_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR against the TLB search, read and write ports.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter  int unsigned TLBNUM = 16,
    localparam int unsigned IW     = $clog2(TLBNUM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [1:0]         op_code,
    input  logic [IW-1:0]      cp0_index,
    input  logic [31:0]        cp0_entryhi,
    input  logic [31:0]        cp0_entrylo0,
    input  logic [31:0]        cp0_entrylo1,
    input  logic [IW-1:0]      cp0_wired,
    input  logic               cp0_wired_we,
    output logic [IW-1:0]      random_o,
    output logic               done_valid,
    output logic [1:0]         done_op,
    output logic               res_index_we,
    output logic [31:0]        res_index,
    output logic               res_entry_we,
    output logic [31:0]        res_entryhi,
    output logic [31:0]        res_entrylo0,
    output logic [31:0]        res_entrylo1,
    output logic [18:0]        tlb_s_vpn2,
    output logic [7:0]         tlb_s_asid,
    output logic               tlb_s_odd_page,
    input  logic               tlb_s_found,
    input  logic [IW-1:0]      tlb_s_index,
    output logic               tlb_we,
    output logic [IW-1:0]      tlb_w_index,
    output logic [ENTRY_W-1:0] tlb_w_entry,
    output logic [IW-1:0]      tlb_r_index,
    input  logic [ENTRY_W-1:0] tlb_r_entry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    tlb_op_e       op_q;
    tlb_entry_t    entry_q;
    logic [IW-1:0] idx_q;
    logic          tlb_we_q;
    logic          done_valid_q;
    logic          res_index_we_q;
    logic          res_entry_we_q;
    logic [31:0]   res_index_q;
    logic [31:0]   res_entryhi_q;
    logic [31:0]   res_entrylo0_q;
    logic [31:0]   res_entrylo1_q;

    tlb_entry_t    cp0_entry;
    tlb_entry_t    rd_entry;
    logic          is_write;
    logic          unused_cp0_bits;

    tlb_random #(.TLBNUM(TLBNUM)) u_random (
        .clk        (clk),
        .reset      (reset),
        .wired_i    (cp0_wired),
        .wired_we_i (cp0_wired_we),
        .random_o   (random_o)
    );

    // CP0 operands in TLB entry form; G is the AND of both EntryLo G bits.
    always_comb begin
        cp0_entry      = '0;
        cp0_entry.vpn2 = cp0_entryhi[31:13];
        cp0_entry.asid = cp0_entryhi[7:0];
        cp0_entry.g    = cp0_entrylo0[LO_G] & cp0_entrylo1[LO_G];
        cp0_entry.pfn0 = cp0_entrylo0[LO_PFN_MSB:LO_PFN_LSB];
        cp0_entry.c0   = cp0_entrylo0[LO_C_MSB:LO_C_LSB];
        cp0_entry.d0   = cp0_entrylo0[LO_D];
        cp0_entry.v0   = cp0_entrylo0[LO_V];
        cp0_entry.pfn1 = cp0_entrylo1[LO_PFN_MSB:LO_PFN_LSB];
        cp0_entry.c1   = cp0_entrylo1[LO_C_MSB:LO_C_LSB];
        cp0_entry.d1   = cp0_entrylo1[LO_D];
        cp0_entry.v1   = cp0_entrylo1[LO_V];
    end

    assign rd_entry        = tlb_entry_t'(tlb_r_entry);
    assign is_write        = (op_code == TLBOP_WI) || (op_code == TLBOP_WR);
    assign unused_cp0_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            op_q           <= TLBOP_P;
            entry_q        <= '0;
            idx_q          <= '0;
            tlb_we_q       <= 1'b0;
            done_valid_q   <= 1'b0;
            res_index_we_q <= 1'b0;
            res_entry_we_q <= 1'b0;
            res_index_q    <= '0;
            res_entryhi_q  <= '0;
            res_entrylo0_q <= '0;
            res_entrylo1_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        state_q  <= EXEC;
                        op_q     <= tlb_op_e'(op_code);
                        entry_q  <= cp0_entry;
                        idx_q    <= (op_code == TLBOP_WR) ? random_o : cp0_index;
                        tlb_we_q <= is_write;
                    end
                end
                EXEC: begin
                    state_q      <= DONE;
                    tlb_we_q     <= 1'b0;
                    done_valid_q <= 1'b1;
                    if (op_q == TLBOP_P) begin
                        res_index_we_q <= 1'b1;
                        res_index_q    <= tlb_s_found ? {{(32-IW){1'b0}}, tlb_s_index}
                                                      : 32'h8000_0000;
                    end
                    if (op_q == TLBOP_R) begin
                        res_entry_we_q <= 1'b1;
                        res_entryhi_q  <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
                        res_entrylo0_q <= make_entrylo(rd_entry.pfn0, rd_entry.c0, rd_entry.d0,
                                                       rd_entry.v0, rd_entry.g);
                        res_entrylo1_q <= make_entrylo(rd_entry.pfn1, rd_entry.c1, rd_entry.d1,
                                                       rd_entry.v1, rd_entry.g);
                    end
                end
                DONE: begin
                    state_q        <= IDLE;
                    done_valid_q   <= 1'b0;
                    res_index_we_q <= 1'b0;
                    res_entry_we_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign op_ready       = (state_q == IDLE);
    assign done_valid     = done_valid_q;
    assign done_op        = op_q;
    assign res_index_we   = res_index_we_q;
    assign res_index      = res_index_q;
    assign res_entry_we   = res_entry_we_q;
    assign res_entryhi    = res_entryhi_q;
    assign res_entrylo0   = res_entrylo0_q;
    assign res_entrylo1   = res_entrylo1_q;
    assign tlb_s_vpn2     = entry_q.vpn2;
    assign tlb_s_asid     = entry_q.asid;
    assign tlb_s_odd_page = 1'b0;
    assign tlb_we         = tlb_we_q;
    assign tlb_w_index    = idx_q;
    assign tlb_w_entry    = entry_q;
    assign tlb_r_index    = idx_q;

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequences the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR against the TLB's search port 1, read port and write port.
- Owns the CP0 Random counter.
- Latches the CP0 operands when an op is accepted, drives exactly one TLB access, and returns the results to CP0 with a one-cycle done pulse.
- Sits between the WB-stage CP0 logic and the tlb instance; search port 0 stays with instruction fetch.

Parameters:
- TLBNUM, 16, number of TLB entries; IW = $clog2(TLBNUM).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  TLB op request from WB
- op_ready  out  1  controller can accept an op (high only in IDLE)
- op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- cp0_index  in  IW  Index[IW-1:0]
- cp0_entryhi  in  32  VPN2[31:13], ASID[7:0]
- cp0_entrylo0  in  32  PFN[25:6], C[5:3], D[2], V[1], G[0]
- cp0_entrylo1  in  32  same layout as entrylo0
- cp0_wired  in  IW  Wired register value
- cp0_wired_we  in  1  Wired is written this cycle
- random_o  out  IW  current Random value
- done_valid  out  1  one-cycle pulse: op finished
- done_op  out  2  op_code of the finished op
- res_index_we  out  1  qualifies res_index (TLBP)
- res_index  out  32  {P, 0..., index}
- res_entry_we  out  1  qualifies res_entryhi/lo0/lo1 (TLBR)
- res_entryhi  out  32  read-back EntryHi
- res_entrylo0  out  32  read-back EntryLo0
- res_entrylo1  out  32  read-back EntryLo1
- tlb_s_vpn2  out  19  search vpn2
- tlb_s_asid  out  8  search asid
- tlb_s_odd_page  out  1  tied 0
- tlb_s_found  in  1  search hit
- tlb_s_index  in  IW  matching entry
- tlb_we  out  1  TLB write enable
- tlb_w_index  out  IW  write index
- tlb_w_entry  out  78  packed tlb_entry_t
- tlb_r_index  out  IW  read index
- tlb_r_entry  in  78  packed tlb_entry_t

Behaviour:
- FSM states: IDLE, EXEC, DONE.
  - IDLE→EXEC on op_valid & op_ready.
  - EXEC→DONE unconditionally; DONE→IDLE unconditionally.
  - op_ready = (state==IDLE). Accept at cycle T gives TLB access at T+1, done_valid at T+2, next accept no earlier than T+3.
- On accept, latch op_code, cp0_entryhi, cp0_entrylo0/1 and the target index: cp0_index for TLBWI/TLBR, random_o for TLBWR.
- TLB port driving:
  - TLB ports are driven from latched values only. tlb_we is 1 solely in EXEC for TLBWI/TLBWR, and 0 in every other state and op.
  - Write packing: vpn2=hi[31:13], asid=hi[7:0], g=lo0[0]&lo1[0], pfnN=loN[25:6], cN=loN[5:3], dN=loN[2], vN=loN[1].
- TLBP: sample tlb_s_found/tlb_s_index at the end of EXEC. res_index = found ? {1'b0, zeros, idx} : {1'b1, 31'b0}. res_index_we=1 in DONE.
- TLBR: sample tlb_r_entry at the end of EXEC.
  - res_entryhi = {vpn2, 5'b0, asid}.
  - res_entryloN = {6'b0, pfnN, cN, dN, vN, g}.
  - res_entry_we=1 in DONE.
- Result regs hold their value until the next op of the same kind; the *_we signals and done_valid are high only in DONE.
- Random counter:
  - random_q is reset to TLBNUM-1.
  - Each cycle, in priority order:
    1. cp0_wired_we → TLBNUM-1.
    2. random_q <= cp0_wired (includes wired ≥ TLBNUM-1) → TLBNUM-1.
    3. Otherwise → random_q-1.
  - Wrap-around goes from wired directly to TLBNUM-1, never below wired.
  - If TLBWR accepts in the same cycle as a Random update, the pre-update random_o value is used.
- Reset values: state IDLE, random_q TLBNUM-1, done_valid 0, tlb_we 0, all res_* 0, all latches 0.
- Reset asserted mid-op forces IDLE asynchronously: no done pulse and no TLB write.
- The caller holds op_valid until accepted; op_code is ignored when op_valid=0.

Decomposition:
- Package tlb_pkg holds:
  - tlb_entry_t, the 78-bit packed struct: vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1.
  - Op codes TLBOP_P/R/WI/WR.
  - EntryLo field positions.
- Sub-module tlb_random holds the Random counter and its wired/wrap logic.

Test Plan:
- After reset: random_o=15, op_ready=1. With wired=0 and no writes, 16 cycles later random_o=15 again, having passed through 0.
- Write cp0_wired=14 with wired_we: random_o→15 next cycle, then 14, 15, 14, ...
- TLBWI with index=3, hi=0x0040_2005, lo0=0x0000_1017, lo1=0x0000_1057: tlb_we=1 for exactly one cycle at T+1, w_index=3, vpn2=0x0201, asid=0x05, g=1, pfn0=0x40, c0=2, d0=1, v0=1; done_valid at T+2.
- TLBP with hi=0x0040_2005 after the above: res_index=0x0000_0003. With hi=0x0080_0005: res_index=0x8000_0000.
- TLBR index=3: res_entryhi=0x0040_2005, res_entrylo0=0x0000_1017, res_entrylo1=0x0000_1057, res_entry_we=1 in DONE only.
- TLBWR accepted while random_o=9: w_index=9. Reset asserted during EXEC: tlb_we drops at once, no done_valid, op_ready=1.
